// File: rtl/trng_word_gen.sv
// TRNG word generator: oscillator bank, 2-flop sync, repetition-count health test, word packer.
// Define TRNG_VN_DEBIAS_EN to insert Von Neumann debiasing between the health test and the packer.

module trng #(
    parameter int NUM_OSCILLATORS = 32,
    parameter int NUM_INVERTER    = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic trng_out
);

    // Clocked stand-in for the ring bank: each ring is a twisted shift ring
    // seeded with a distinct phase, and the rings are XORed together.
    logic [NUM_INVERTER-1:0] ring [NUM_OSCILLATORS];
    logic                    mix;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_OSCILLATORS; o++) begin
                ring[o] <= NUM_INVERTER'(o * 37 + 1);
            end
        end else if (en) begin
            for (int o = 0; o < NUM_OSCILLATORS; o++) begin
                ring[o] <= {ring[o][NUM_INVERTER-2:0], ~ring[o][NUM_INVERTER-1]};
            end
        end
    end

    always_comb begin
        mix = 1'b0;
        for (int o = 0; o < NUM_OSCILLATORS; o++) begin
            mix = mix ^ ring[o][0];
        end
    end

    assign trng_out = mix;

endmodule

module trng_word_gen #(
    parameter int NUM_OSCILLATORS = 32,
    parameter int NUM_INVERTER    = 7,
    parameter int WORD_WIDTH      = 32,
    parameter int REP_LIMIT       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trng_en,
    input  logic                  test_mode,
    input  logic                  test_bit,
    input  logic                  clear_fail,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic                  health_fail
);

    localparam int CW = $clog2(WORD_WIDTH + 1);
    localparam int RW = $clog2(REP_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FULL,
        FAIL
    } state_t;

    state_t                state;
    logic                  trng_out;
    logic                  raw_bit;
    logic                  sync1;
    logic                  sync2;
    logic [WORD_WIDTH-1:0] shift_reg;
    logic [WORD_WIDTH-1:0] shift_next;
    logic [CW-1:0]         bit_cnt;
    logic [RW-1:0]         rep_cnt;
    logic [RW-1:0]         rep_next;
    logic                  last_bit;
    logic                  xfer;
    logic                  trip;
    logic                  push_en;
    logic                  push_bit;
    logic                  word_done;
`ifdef TRNG_VN_DEBIAS_EN
    logic                  vn_have;
    logic                  vn_a;
`endif

    trng #(
        .NUM_OSCILLATORS(NUM_OSCILLATORS),
        .NUM_INVERTER   (NUM_INVERTER)
    ) u_trng (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (trng_en & ~test_mode),
        .trng_out(trng_out)
    );

    always_comb begin
        raw_bit  = test_mode ? test_bit : trng_out;
        xfer     = rd_valid & rd_ready;
        rep_next = ((rep_cnt != '0) && (sync2 == last_bit))
                 ? rep_cnt + RW'(1) : RW'(1);
        trip     = (rep_next == RW'(REP_LIMIT));
`ifdef TRNG_VN_DEBIAS_EN
        // Second sample of a pair; only a differing pair yields its first bit.
        push_en  = vn_have && (vn_a != sync2);
        push_bit = vn_a;
`else
        push_en  = 1'b1;
        push_bit = sync2;
`endif
        shift_next = {shift_reg[WORD_WIDTH-2:0], push_bit};
        word_done  = push_en && (bit_cnt == CW'(WORD_WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= '0;
            last_bit    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            health_fail <= 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
            vn_have     <= 1'b0;
            vn_a        <= 1'b0;
`endif
        end else begin
            sync1 <= raw_bit;
            sync2 <= sync1;
            if (state == FAIL) begin
                if (clear_fail) begin
                    health_fail <= 1'b0;
                    shift_reg   <= '0;
                    bit_cnt     <= '0;
                    rep_cnt     <= '0;
`ifdef TRNG_VN_DEBIAS_EN
                    vn_have     <= 1'b0;
`endif
                    state       <= IDLE;
                end
            end else if (!trng_en) begin
                // Partial word is dropped; the offered word stays on the port.
                state   <= IDLE;
                bit_cnt <= '0;
`ifdef TRNG_VN_DEBIAS_EN
                vn_have <= 1'b0;
`endif
                if (xfer) begin
                    rd_valid <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state <= COLLECT;
                        if (xfer) begin
                            rd_valid <= 1'b0;
                        end
                    end
                    COLLECT: begin
                        rep_cnt  <= rep_next;
                        last_bit <= sync2;
                        if (trip) begin
                            health_fail <= 1'b1;
                            rd_valid    <= 1'b0;
                            state       <= FAIL;
                        end else begin
`ifdef TRNG_VN_DEBIAS_EN
                            vn_have <= ~vn_have;
                            if (!vn_have) begin
                                vn_a <= sync2;
                            end
`endif
                            if (push_en) begin
                                shift_reg <= shift_next;
                                bit_cnt   <= bit_cnt + CW'(1);
                            end
                            if (word_done) begin
                                if (!rd_valid || xfer) begin
                                    rd_data  <= shift_next;
                                    rd_valid <= 1'b1;
                                    bit_cnt  <= '0;
                                end else begin
                                    state <= FULL;
                                end
                            end else if (xfer) begin
                                rd_valid <= 1'b0;
                            end
                        end
                    end
                    FULL: begin
                        if (xfer) begin
                            rd_data <= shift_reg;
                            bit_cnt <= '0;
                            state   <= COLLECT;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trng_word_gen.sv
// Bench for trng_word_gen: directed scenarios plus random traffic against a queue-based model.
// Model honours TRNG_VN_DEBIAS_EN when the bench is built with it.

module tb_trng_word_gen;

    localparam int W   = 8;
    localparam int LIM = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         trng_en = 1'b0;
    logic         test_mode = 1'b1;
    logic         test_bit = 1'b0;
    logic         clear_fail = 1'b0;
    logic         rd_ready = 1'b0;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic         health_fail;

    int checks = 0;
    int errors = 0;

    bit stim[$];
    bit fill = 1'b0;

    // reference model state
    bit           m_pipe[$] = '{1'b0, 1'b0};
    bit           m_bits[$];
    bit           m_vn_have = 1'b0;
    bit           m_vn_a = 1'b0;
    bit           m_run = 1'b0;
    bit           m_full = 1'b0;
    bit           m_fail = 1'b0;
    int           m_rep = 0;
    bit           m_last = 1'b0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_data = '0;

    trng_word_gen #(
        .NUM_OSCILLATORS(32),
        .NUM_INVERTER   (7),
        .WORD_WIDTH     (W),
        .REP_LIMIT      (LIM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trng_en    (trng_en),
        .test_mode  (test_mode),
        .test_bit   (test_bit),
        .clear_fail (clear_fail),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack_bits();
        logic [W-1:0] v = '0;
        foreach (m_bits[i]) v = {v[W-2:0], m_bits[i]};
        return v;
    endfunction

    task automatic model_edge();
        bit s;
        bit xfer;
        s = m_pipe.pop_front();
        m_pipe.push_back(test_bit);
        xfer = m_valid && rd_ready;
        if (!rst_n) begin
            m_pipe = '{1'b0, 1'b0};
            m_bits.delete();
            m_vn_have = 0; m_run = 0; m_full = 0; m_fail = 0;
            m_rep = 0; m_last = 0; m_valid = 0; m_data = '0;
            return;
        end
        if (m_fail) begin
            if (clear_fail) begin
                m_fail = 0; m_bits.delete(); m_vn_have = 0;
                m_rep = 0; m_run = 0;
            end
            return;
        end
        if (!trng_en) begin
            m_run = 0; m_full = 0; m_bits.delete(); m_vn_have = 0;
            if (xfer) m_valid = 0;
            return;
        end
        if (!m_run) begin
            m_run = 1;
            if (xfer) m_valid = 0;
            return;
        end
        if (m_full) begin
            if (xfer) begin
                m_data = pack_bits();
                m_bits.delete();
                m_full = 0;
            end
            return;
        end
        m_rep = (m_rep != 0 && s == m_last) ? m_rep + 1 : 1;
        m_last = s;
        if (m_rep == LIM) begin
            m_fail = 1; m_valid = 0; m_run = 0;
            return;
        end
`ifdef TRNG_VN_DEBIAS_EN
        if (!m_vn_have) begin
            m_vn_a = s; m_vn_have = 1;
        end else begin
            m_vn_have = 0;
            if (m_vn_a != s) m_bits.push_back(m_vn_a);
        end
`else
        m_bits.push_back(s);
`endif
        if (m_bits.size() == W) begin
            if (!m_valid || xfer) begin
                m_data = pack_bits();
                m_valid = 1;
                m_bits.delete();
            end else begin
                m_full = 1;
            end
        end else if (xfer) begin
            m_valid = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("rd_data", 32'(rd_data), 32'(m_data));
        chk("health_fail", 32'(health_fail), 32'(m_fail));
    endtask

    task automatic step();
        if (stim.size() != 0) begin
            test_bit = stim.pop_front();
        end else begin
            fill = ~fill;
            test_bit = fill;
        end
        cyc();
    endtask

    task automatic do_reset();
        stim.delete();
        trng_en = 0; clear_fail = 0;
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) stim.push_back(w[i]);
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (rd_valid !== 1'b1 && n < max) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    endtask

    // first enable cycle applies the first bit so that it is the first sample
    task automatic start_stream();
        trng_en = 0;
        step();
        trng_en = 1;
    endtask

    initial begin
        do_reset();
        chk("reset_valid", 32'(rd_valid), 32'd0);
        chk("reset_data", 32'(rd_data), 32'd0);
        chk("reset_fail", 32'(health_fail), 32'd0);

        // alternating word, consumer ready
        rd_ready = 1;
        push_word(8'hAA);
        start_stream();
        wait_valid("t1", 80);
`ifndef TRNG_VN_DEBIAS_EN
        chk("t1_data", 32'(rd_data), 32'hAA);
`endif

        // back-pressure: second word held, third dropped
        do_reset();
        rd_ready = 0;
        push_word(8'hAA); push_word(8'h55); push_word(8'h0F);
        start_stream();
        repeat (34) step();
`ifndef TRNG_VN_DEBIAS_EN
        chk("t2_held_valid", 32'(rd_valid), 32'd1);
        chk("t2_held_data", 32'(rd_data), 32'hAA);
`endif
        rd_ready = 1;
        step();
`ifndef TRNG_VN_DEBIAS_EN
        chk("t2_next_valid", 32'(rd_valid), 32'd1);
        chk("t2_next_data", 32'(rd_data), 32'h55);
`endif
        rd_ready = 0;
        repeat (4) step();

        // repetition failure and recovery
        do_reset();
        rd_ready = 1;
        repeat (LIM) stim.push_back(1'b1);
        start_stream();
        repeat (20) step();
        chk("t3_fail", 32'(health_fail), 32'd1);
        chk("t3_valid", 32'(rd_valid), 32'd0);
        clear_fail = 1;
        step();
        clear_fail = 0;
        chk("t3_cleared", 32'(health_fail), 32'd0);
        wait_valid("t3_fresh", 60);

        // debias pattern
        do_reset();
        rd_ready = 1;
        repeat (8) begin
            stim.push_back(1); stim.push_back(0); stim.push_back(1); stim.push_back(1);
            stim.push_back(0); stim.push_back(1); stim.push_back(0); stim.push_back(0);
        end
        start_stream();
        wait_valid("t4", 100);
`ifdef TRNG_VN_DEBIAS_EN
        chk("t4_data", 32'(rd_data), 32'hAA);
`else
        chk("t4_data", 32'(rd_data), 32'hB4);
`endif

        // enable dropped mid-word
        do_reset();
        rd_ready = 1;
        stim.push_back(1); stim.push_back(1); stim.push_back(0);
        stim.push_back(0); stim.push_back(1);
        start_stream();
        repeat (6) step();
        trng_en = 0;
        step();
        push_word(8'h3C);
        start_stream();
        wait_valid("t5", 60);
`ifndef TRNG_VN_DEBIAS_EN
        chk("t5_data", 32'(rd_data), 32'h3C);
`endif

        // reset mid-word with a word on the port
        do_reset();
        rd_ready = 0;
        push_word(8'hAA);
        start_stream();
        wait_valid("t6", 60);
        repeat (3) step();
        rst_n = 0;
        step();
        rst_n = 1;
        chk("t6_valid", 32'(rd_valid), 32'd0);
        chk("t6_data", 32'(rd_data), 32'd0);
        chk("t6_fail", 32'(health_fail), 32'd0);

        // random traffic, biased bits so the health test trips now and then
        for (int i = 0; i < 3000; i++) begin
            test_bit   = ($urandom_range(0, 9) < 7);
            rd_ready   = ($urandom_range(0, 2) != 0);
            trng_en    = ($urandom_range(0, 49) != 0);
            clear_fail = ($urandom_range(0, 39) == 0);
            rst_n      = ($urandom_range(0, 699) != 0);
            cyc();
        end
        rst_n = 1; clear_fail = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
